logic_gate_struct: RTL and testbench
====================================

Name: logic_gate_struct

Overview:
- Two-input basic-gate block. Produces AND, NAND, NOR, OR, XNOR and XOR of inputs A and B simultaneously.
- Built structurally from gate primitive instances, one gate per output, with no behavioural expressions.
- Used as a leaf primitive-check block.
- Also provides a registered snapshot of all six results for synchronous consumers.

Parameters:
- None.

Ports:
- clk     input   1  single clock; used only by the snapshot register
- rst_n   input   1  asynchronous active-low reset; clears only the snapshot register
- A       input   1  gate operand A
- B       input   1  gate operand B
- Y_and   output  1  A AND B, combinational
- Y_nand  output  1  NOT(A AND B), combinational
- Y_nor   output  1  NOT(A OR B), combinational
- Y_or    output  1  A OR B, combinational
- Y_xnor  output  1  NOT(A XOR B), combinational
- Y_xor   output  1  A XOR B, combinational
- y_q     output  6  registered snapshot. Bit 5 = and, 4 = nand, 3 = nor, 2 = or, 1 = xnor, 0 = xor.

Interface note: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Combinational outputs Y_*:
  - Each is driven by exactly one gate primitive instance (and, nand, nor, or, xnor, xor) with inputs A and B.
  - Zero-cycle latency; purely combinational.
  - They are independent of clk and rst_n and stay valid while rst_n is low.
  - Settle within one simulation time unit after any change of A or B, with no zero-delay glitch requirement beyond that.
- Truth table (A B -> and nand nor or xnor xor):
  - 0 0 -> 0 1 1 0 1 0
  - 0 1 -> 0 1 0 1 0 1
  - 1 0 -> 0 1 0 1 0 1
  - 1 1 -> 1 0 0 1 1 0
- Unknown inputs: X/Z on A or B propagates per standard gate-primitive semantics.
  - Example: A=0, B=X gives Y_and=0, Y_nand=1, Y_or=X.
- Registered output y_q:
  - On rst_n falling (asynchronous): y_q = 6'b000000 immediately, without waiting for a clock edge.
  - While rst_n = 0: y_q holds 0 regardless of clk, A and B.
  - On each rising clk edge with rst_n = 1: y_q <= {Y_and, Y_nand, Y_nor, Y_or, Y_xnor, Y_xor}, sampled from the current A and B. Latency is one clock.
  - Reset deassertion is synchronous to clk: the first capture occurs on the first rising edge after rst_n goes high.
  - Reset asserted mid-operation: y_q clears at once. Combinational outputs are unaffected.
- No enable, no handshake, no internal state other than y_q.

Test Plan:
- A=0,B=0, wait 1 time unit -> Y_and=0 Y_nand=1 Y_nor=1 Y_or=0 Y_xnor=1 Y_xor=0.
- A=0,B=1 then A=1,B=0, each checked after 1 time unit -> both give Y_and=0 Y_nand=1 Y_nor=0 Y_or=1 Y_xnor=0 Y_xor=1.
- A=1,B=1 -> Y_and=1 Y_nand=0 Y_nor=0 Y_or=1 Y_xnor=1 Y_xor=0.
- Hold rst_n=0 and sweep all four A/B combinations with clk toggling -> Y_* follow the truth table; y_q stays 6'b000000.
- Release rst_n, set A=1,B=1, apply one rising edge -> y_q=6'b100110.
  - Then set A=0,B=1 -> y_q stays 6'b100110 until the next rising edge, then becomes 6'b010101.
- With y_q=6'b010101, pull rst_n low between clock edges -> y_q=6'b000000 immediately; Y_* unchanged.

Source files
------------

// File: rtl/logic_gate_struct.sv
// ----------------------------------------------------------------------------
// logic_gate_struct
//
// Two-input basic-gate leaf block. Each of the six combinational outputs comes
// from exactly one gate primitive instance, so X/Z on the operands follows
// standard primitive semantics. A six-bit registered snapshot of all results
// is also provided for synchronous consumers.
//
// Ports:
//   clk     in   1  clock, used only by the snapshot register
//   rst_n   in   1  asynchronous active-low reset, clears only y_q
//   A       in   1  gate operand A
//   B       in   1  gate operand B
//   Y_and   out  1  A & B
//   Y_nand  out  1  ~(A & B)
//   Y_nor   out  1  ~(A | B)
//   Y_or    out  1  A | B
//   Y_xnor  out  1  ~(A ^ B)
//   Y_xor   out  1  A ^ B
//   y_q     out  6  registered {and, nand, nor, or, xnor, xor}
// ----------------------------------------------------------------------------
module logic_gate_struct (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    output logic       Y_and,
    output logic       Y_nand,
    output logic       Y_nor,
    output logic       Y_or,
    output logic       Y_xnor,
    output logic       Y_xor,
    output logic [5:0] y_q
);

    // One primitive per output; these never see clk or rst_n, so they stay
    // valid while the snapshot register is held in reset.
    and  u_and  (Y_and,  A, B);
    nand u_nand (Y_nand, A, B);
    nor  u_nor  (Y_nor,  A, B);
    or   u_or   (Y_or,   A, B);
    xnor u_xnor (Y_xnor, A, B);
    xor  u_xor  (Y_xor,  A, B);

    // Snapshot takes the primitive outputs rather than recomputing from A/B,
    // so the registered view is guaranteed to match the combinational one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= 6'b000000;
        end else begin
            y_q <= {Y_and, Y_nand, Y_nor, Y_or, Y_xnor, Y_xor};
        end
    end

endmodule

// File: tb/tb_logic_gate_struct.sv
// ----------------------------------------------------------------------------
// tb_logic_gate_struct
//
// Directed bench for logic_gate_struct. Expected values are hand-computed
// truth-table constants indexed by {A, B}, in y_q bit order
// {and, nand, nor, or, xnor, xor}.
// ----------------------------------------------------------------------------
module tb_logic_gate_struct;

    logic       clk;
    logic       rst_n;
    logic       A;
    logic       B;
    logic       Y_and;
    logic       Y_nand;
    logic       Y_nor;
    logic       Y_or;
    logic       Y_xnor;
    logic       Y_xor;
    logic [5:0] y_q;
    logic [5:0] y_comb;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed truth table, index = {A, B}.
    logic [5:0] exp_tab [4];

    logic_gate_struct dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .Y_and  (Y_and),
        .Y_nand (Y_nand),
        .Y_nor  (Y_nor),
        .Y_or   (Y_or),
        .Y_xnor (Y_xnor),
        .Y_xor  (Y_xor),
        .y_q    (y_q)
    );

    assign y_comb = {Y_and, Y_nand, Y_nor, Y_or, Y_xnor, Y_xor};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        exp_tab[0] = 6'b011010;  // A=0 B=0
        exp_tab[1] = 6'b010101;  // A=0 B=1
        exp_tab[2] = 6'b010101;  // A=1 B=0
        exp_tab[3] = 6'b100110;  // A=1 B=1

        rst_n = 1'b0;
        A     = 1'b0;
        B     = 1'b0;
        #1;
        check_eq("reset_y_q", y_q, 6'b000000);
        check_eq("reset_comb_00", y_comb, exp_tab[0]);

        // Sweep all operand combinations while held in reset with clk running.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            @(negedge clk);
            A = ab[1];
            B = ab[0];
            #1;
            check_eq($sformatf("rst_comb_%0d", i), y_comb, exp_tab[i]);
            @(posedge clk);
            #1;
            check_eq($sformatf("rst_hold_y_q_%0d", i), y_q, 6'b000000);
            check_eq($sformatf("rst_comb_after_edge_%0d", i), y_comb, exp_tab[i]);
        end

        // Release reset between edges; first capture on the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        A     = 1'b1;
        B     = 1'b1;
        #1;
        check_eq("comb_11", y_comb, exp_tab[3]);
        check_eq("no_capture_before_edge", y_q, 6'b000000);
        @(posedge clk);
        #1;
        check_eq("capture_11", y_q, 6'b100110);

        @(negedge clk);
        A = 1'b0;
        B = 1'b1;
        #1;
        check_eq("comb_01", y_comb, exp_tab[1]);
        check_eq("hold_until_edge", y_q, 6'b100110);
        @(posedge clk);
        #1;
        check_eq("capture_01", y_q, 6'b010101);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_clear_y_q", y_q, 6'b000000);
        check_eq("async_comb_unchanged", y_comb, exp_tab[1]);
        @(posedge clk);
        #1;
        check_eq("async_hold_y_q", y_q, 6'b000000);

        // Registered path for every combination after re-release.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            @(negedge clk);
            A = ab[1];
            B = ab[0];
            #1;
            check_eq($sformatf("comb_%0d", i), y_comb, exp_tab[i]);
            @(posedge clk);
            #1;
            check_eq($sformatf("capture_%0d", i), y_q, exp_tab[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
